// File: rtl/ysyx_22040759_hazard_ctrl.sv
// Pipeline hazard sequencer: turns load-use, mul/div wait, MEM bus wait and EX redirect
// into per-stage stall/flush enables, plus saturating perf counters and an MD watchdog.
module ysyx_22040759_hazard_ctrl #(
  parameter int CNT_W  = 32,
  parameter int MD_TMO = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_tkn,
  input  logic             ex_md_start,
  input  logic             ex_md_done,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             mem_wb_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             dbg_state_o
);

  localparam int TMO_W = (MD_TMO > 1) ? $clog2(MD_TMO + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MD_TMO);
  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic md_busy;
  logic redirect;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  assign md_busy = !ex_md_done && ((state_q == ST_MD_WAIT) || ex_md_start);

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    redirect     = 1'b0;
    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (mem_busy) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_stall = 1'b1;
    end else if (md_busy) begin
      // EX holds its mul/div; a taken branch in EX waits until EX releases.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (ex_branch_tkn) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      redirect     = 1'b1;
    end else if (load_use) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_flush  = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    md_timeout_d = md_timeout_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (ex_md_start && !ex_md_done && !mem_busy) begin
          state_d = ST_MD_WAIT;
          tmo_d   = '0;
        end
      end
      ST_MD_WAIT: begin
        if (ex_md_done) state_d = ST_RUN;
        if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_ONE;
        // MD_TMO == 0 turns the watchdog off entirely.
        if ((MD_TMO != 0) && (tmo_q == TMO_MAX - TMO_ONE)) md_timeout_d = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    if (pc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      tmo_q        <= '0;
      md_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      md_timeout_q <= md_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign md_timeout   = md_timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
  assign dbg_state_o  = logic'(state_q);

endmodule

// File: tb/tb_ysyx_22040759_hazard_ctrl.sv
// Bench for the hazard sequencer: directed scenarios followed by random traffic,
// all scored against a cycle-level reference model of the stall/flush rules.
module tb_ysyx_22040759_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int MD_TMO  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_rs1_used, id_rs2_used;
  logic             ex_mem_read, ex_branch_tkn, ex_md_start, ex_md_done, mem_busy;
  logic             pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic             if_id_flush, id_ex_flush, ex_mem_flush;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic             dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_md_wait;
  int m_wait_cycles;
  bit m_timeout;
  int m_stall_cnt;
  int m_flush_cnt;

  logic [7:0] exp_q[$];

  ysyx_22040759_hazard_ctrl #(.CNT_W(CNT_W), .MD_TMO(MD_TMO)) dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_tkn(ex_branch_tkn),
    .ex_md_start(ex_md_start), .ex_md_done(ex_md_done), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .md_timeout(md_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // {pc, if_id, id_ex, ex_mem, mem_wb stall, if_id, id_ex, ex_mem flush}
  function automatic logic [7:0] model_ctl();
    bit hazard;
    if (reset) return 8'b00000_111;
    if (mem_busy) return 8'b11111_000;
    if (!ex_md_done && (m_md_wait || ex_md_start)) return 8'b11100_001;
    if (ex_branch_tkn) return 8'b00000_110;
    hazard = 1'b0;
    if (ex_mem_read && ex_rd != 0) begin
      if (id_rs1_used && id_rs1 == ex_rd) hazard = 1'b1;
      if (id_rs2_used && id_rs2 == ex_rd) hazard = 1'b1;
    end
    if (hazard) return 8'b11000_010;
    return 8'b00000_000;
  endfunction

  task automatic model_clock(input logic [7:0] ctl);
    if (reset) begin
      m_md_wait = 1'b0; m_wait_cycles = 0; m_timeout = 1'b0;
      m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (ctl[7] && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if (ctl == 8'b00000_110 && m_flush_cnt < CNT_MAX) m_flush_cnt++;
      if (m_md_wait) begin
        m_wait_cycles++;
        if (MD_TMO != 0 && m_wait_cycles >= MD_TMO) m_timeout = 1'b1;
        if (ex_md_done) m_md_wait = 1'b0;
      end else if (ex_md_start && !ex_md_done && !mem_busy) begin
        m_md_wait = 1'b1;
        m_wait_cycles = 0;
      end
    end
  endtask

  // one checked cycle: inputs already driven after a negedge
  task automatic cycle();
    logic [7:0] exp_ctl, act_ctl;
    #1;
    exp_ctl = model_ctl();
    exp_q.push_back(exp_ctl);
    act_ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
               if_id_flush, id_ex_flush, ex_mem_flush};
    check_eq("ctl", 32'(act_ctl), 32'(exp_q.pop_front()));
    check_eq("stall_cycles", 32'(stall_cycles), 32'(m_stall_cnt));
    check_eq("flush_events", 32'(flush_events), 32'(m_flush_cnt));
    check_eq("md_timeout", 32'(md_timeout), 32'(m_timeout));
    check_eq("state", 32'(dbg_state_o), 32'(m_md_wait));
    @(posedge clock);
    model_clock(exp_ctl);
    @(negedge clock);
  endtask

  task automatic drive_idle();
    reset = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_tkn = 1'b0;
    ex_md_start = 1'b0; ex_md_done = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 2));
  endfunction

  task automatic drive_random();
    reset         = ($urandom_range(0, 99) < 2);
    id_rs1        = pick_reg();
    id_rs2        = pick_reg();
    ex_rd         = pick_reg();
    id_rs1_used   = 1'($urandom_range(0, 1));
    id_rs2_used   = 1'($urandom_range(0, 1));
    ex_mem_read   = 1'($urandom_range(0, 1));
    ex_branch_tkn = ($urandom_range(0, 99) < 15);
    ex_md_start   = ($urandom_range(0, 99) < 10);
    ex_md_done    = ($urandom_range(0, 99) < 12);
    mem_busy      = ($urandom_range(0, 99) < 15);
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_eq("rst_stall_cnt", 32'(stall_cycles), 32'd0);
    check_eq("rst_flush_cnt", 32'(flush_events), 32'd0);
    check_eq("rst_timeout", 32'(md_timeout), 32'd0);
    check_eq("rst_flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'b111);
    cycle();
    reset = 1'b0;

    // load-use: lw x5 in EX, add reading x5 in ID
    ex_rd = 5'd5; ex_mem_read = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    cycle();
    check_eq("lu_stall_cnt", 32'(stall_cycles), 32'd1);
    drive_idle();
    cycle();
    // x0 and unused-operand cases
    ex_rd = 5'd0; ex_mem_read = 1'b1; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    cycle();
    drive_idle();
    ex_rd = 5'd5; ex_mem_read = 1'b1; id_rs2 = 5'd5; id_rs2_used = 1'b0;
    cycle();
    check_eq("no_hazard_cnt", 32'(stall_cycles), 32'd1);

    // mul/div with done four cycles after start
    do_reset();
    ex_md_start = 1'b1;
    cycle();
    ex_md_start = 1'b0;
    repeat (3) cycle();
    ex_md_done = 1'b1;
    cycle();
    ex_md_done = 1'b0;
    cycle();
    check_eq("md_stall_cnt", 32'(stall_cycles), 32'd4);
    check_eq("md_state", 32'(dbg_state_o), 32'd0);

    // branch concurrent with load-use
    do_reset();
    ex_branch_tkn = 1'b1; ex_rd = 5'd7; ex_mem_read = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;
    cycle();
    drive_idle();
    cycle();
    check_eq("br_flush_cnt", 32'(flush_events), 32'd1);
    check_eq("br_stall_cnt", 32'(stall_cycles), 32'd0);

    // branch held through three busy cycles
    do_reset();
    ex_branch_tkn = 1'b1; mem_busy = 1'b1;
    repeat (3) cycle();
    check_eq("busy_flush_cnt", 32'(flush_events), 32'd0);
    mem_busy = 1'b0;
    cycle();
    drive_idle();
    cycle();
    check_eq("busy_stall_cnt", 32'(stall_cycles), 32'd3);
    check_eq("busy_br_cnt", 32'(flush_events), 32'd1);

    // watchdog: no done for ten wait cycles
    do_reset();
    ex_md_start = 1'b1;
    cycle();
    ex_md_start = 1'b0;
    repeat (7) cycle();
    check_eq("tmo_before", 32'(md_timeout), 32'd0);
    cycle();
    check_eq("tmo_after", 32'(md_timeout), 32'd1);
    repeat (2) cycle();
    do_reset();
    cycle();
    check_eq("tmo_rst_timeout", 32'(md_timeout), 32'd0);
    check_eq("tmo_rst_stall", 32'(stall_cycles), 32'd0);
    check_eq("tmo_rst_state", 32'(dbg_state_o), 32'd0);

    // counter saturation
    mem_busy = 1'b1;
    repeat (20) cycle();
    check_eq("sat_stall_cnt", 32'(stall_cycles), 32'(CNT_MAX));
    drive_idle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
